// File: rtl/bit_deserializer_16.sv
// Serial-to-parallel 16-bit word assembler: one accepted bit per cycle is
// written into the position selected by bit_idx, and the full word is offered on a valid/ready port.
module bit_deserializer_16 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic [15:0] word_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  bit_idx
);

  // Handshakes: a bit moves when in_valid & in_ready; a word moves when
  // out_valid & out_ready. in_ready never looks at in_valid.

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state;
  logic [3:0]  pos;
  logic [15:0] wr_en;
  logic [15:0] bit_mask;
  logic        accept;
  logic        take;

  // The state register is observable directly: out_valid is 1 exactly in HOLD.
  assign out_valid = (state == HOLD);
  assign in_ready  = (state == FILL) ? 1'b1 : out_ready;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_comb begin
    pos = bit_idx;
    if (MSB_FIRST) begin
      pos = 4'd15 - bit_idx;
    end
  end

  assign wr_en    = 16'd1 << pos;
  assign bit_mask = wr_en & {16{in_bit}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      word_out <= 16'h0000;
      bit_idx  <= 4'd0;
    end else begin
      case (state)
        FILL: begin
          if (clear) begin
            bit_idx <= 4'd0;
          end else if (accept) begin
            // The first bit of a word wipes whatever the previous word left behind.
            if (bit_idx == 4'd0) begin
              word_out <= bit_mask;
            end else begin
              word_out <= (word_out & ~wr_en) | bit_mask;
            end
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd15) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // bit_idx is already 0 here, so pos addresses the first bit of the next word.
          if (take) begin
            state <= FILL;
            if (accept && !clear) begin
              word_out <= bit_mask;
              bit_idx  <= 4'd1;
            end else begin
              bit_idx  <= 4'd0;
            end
          end else if (clear) begin
            bit_idx <= 4'd0;
          end
        end
        default: begin
          state   <= FILL;
          bit_idx <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_deserializer_16.sv
// Directed bench for bit_deserializer_16: one LSB-first and one MSB-first
// instance, with hand-computed words, handshake and clear scenarios.
module tb_bit_deserializer_16;

  logic clk;
  logic rst;

  logic        l_in_bit, l_in_valid, l_in_ready, l_clear, l_out_valid, l_out_ready;
  logic [15:0] l_word_out;
  logic [3:0]  l_bit_idx;

  logic        m_in_bit, m_in_valid, m_in_ready, m_clear, m_out_valid, m_out_ready;
  logic [15:0] m_word_out;
  logic [3:0]  m_bit_idx;

  int n_cmp;
  int n_fail;

  logic [15:0] exp_q[$];

  bit_deserializer_16 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_bit(l_in_bit), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .clear(l_clear), .word_out(l_word_out),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .bit_idx(l_bit_idx)
  );

  bit_deserializer_16 #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_bit(m_in_bit), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .clear(m_clear), .word_out(m_word_out),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .bit_idx(m_bit_idx)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    l_in_valid = 1'b1; l_in_bit = 1'b1; l_clear = 1'b0; l_out_ready = 1'b0;
    m_in_valid = 1'b1; m_in_bit = 1'b1; m_clear = 1'b0; m_out_ready = 1'b0;
    step();
    step();
    n_cmp++;
    if (l_word_out !== 16'h0000 || l_out_valid !== 1'b0 || l_bit_idx !== 4'd0 || l_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_lsb: word=%h ov=%b idx=%0d ir=%b, expected 0000 0 0 1",
               l_word_out, l_out_valid, l_bit_idx, l_in_ready);
    end
    n_cmp++;
    if (m_word_out !== 16'h0000 || m_out_valid !== 1'b0 || m_bit_idx !== 4'd0 || m_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_msb: word=%h ov=%b idx=%0d ir=%b, expected 0000 0 0 1",
               m_word_out, m_out_valid, m_bit_idx, m_in_ready);
    end
    l_in_valid = 1'b0;
    m_in_valid = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++;
    if (l_bit_idx !== 4'd0 || l_word_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_nocapture: idx=%0d word=%h, expected 0 0000", l_bit_idx, l_word_out);
    end
  endtask

  task automatic test_lsb_word();
    logic [15:0] w;
    int pulses;
    w = 16'hA5C3;
    pulses = 0;
    l_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      l_in_bit = w[i];
      l_in_valid = 1'b1;
      n_cmp++;
      if (l_bit_idx !== 4'(i)) begin
        n_fail++;
        $display("FAIL lsb_idx_seq: idx=%0d expected %0d", l_bit_idx, i);
      end
      step();
      if (l_out_valid === 1'b1) pulses++;
    end
    l_in_valid = 1'b0;
    n_cmp++;
    if (l_out_valid !== 1'b1 || l_word_out !== 16'hA5C3 || l_bit_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL lsb_word: ov=%b word=%h idx=%0d, expected 1 a5c3 0",
               l_out_valid, l_word_out, l_bit_idx);
    end
    step();
    if (l_out_valid === 1'b1) pulses++;
    n_cmp++;
    if (pulses != 1 || l_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_pulse_width: pulses=%0d ov=%b, expected 1 0", pulses, l_out_valid);
    end
  endtask

  task automatic test_msb_backpressure();
    logic [15:0] w;
    w = 16'h1234;
    m_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_in_bit = w[15 - i];
      m_in_valid = 1'b1;
      step();
    end
    n_cmp++;
    if (m_out_valid !== 1'b1 || m_word_out !== 16'h1234 || m_bit_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL msb_word: ov=%b word=%h idx=%0d, expected 1 1234 0",
               m_out_valid, m_word_out, m_bit_idx);
    end
    m_in_bit = 1'b1;
    m_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (m_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_in_ready: ir=%b expected 0 (cycle %0d)", m_in_ready, i);
      end
      step();
      n_cmp++;
      if (m_out_valid !== 1'b1 || m_word_out !== 16'h1234 || m_bit_idx !== 4'd0) begin
        n_fail++;
        $display("FAIL hold_frozen: ov=%b word=%h idx=%0d, expected 1 1234 0",
                 m_out_valid, m_word_out, m_bit_idx);
      end
    end
    w = 16'h8001;
    m_out_ready = 1'b1;
    m_in_bit = w[15];
    #1;
    n_cmp++;
    if (m_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release_ready: ir=%b expected 1", m_in_ready);
    end
    step();
    n_cmp++;
    if (m_out_valid !== 1'b0 || m_bit_idx !== 4'd1 || m_word_out !== 16'h8000) begin
      n_fail++;
      $display("FAIL take_with_accept: ov=%b idx=%0d word=%h, expected 0 1 8000",
               m_out_valid, m_bit_idx, m_word_out);
    end
    for (int i = 1; i < 16; i++) begin
      m_in_bit = w[15 - i];
      step();
    end
    m_in_valid = 1'b0;
    n_cmp++;
    if (m_out_valid !== 1'b1 || m_word_out !== 16'h8001) begin
      n_fail++;
      $display("FAIL msb_second_word: ov=%b word=%h, expected 1 8001", m_out_valid, m_word_out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    int last_pulse;
    int n_pulse;
    logic [15:0] exp_w;
    words[0] = 16'hFFFF;
    words[1] = 16'h0000;
    words[2] = 16'h5555;
    for (int k = 0; k < 3; k++) exp_q.push_back(words[k]);
    last_pulse = -1;
    n_pulse = 0;
    l_out_ready = 1'b1;
    l_in_valid = 1'b1;
    for (int k = 0; k < 48; k++) begin
      l_in_bit = words[k / 16][k % 16];
      step();
      if (l_out_valid === 1'b1) begin
        n_pulse++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_cmp++;
        if (l_word_out !== exp_w) begin
          n_fail++;
          $display("FAIL b2b_word: word=%h expected %h", l_word_out, exp_w);
        end
        if (last_pulse >= 0) begin
          n_cmp++;
          if (k - last_pulse != 16) begin
            n_fail++;
            $display("FAIL b2b_spacing: gap=%0d expected 16", k - last_pulse);
          end
        end
        last_pulse = k;
      end
    end
    l_in_valid = 1'b0;
    step();
    n_cmp++;
    if (n_pulse != 3 || exp_q.size() != 0 || l_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: pulses=%0d left=%0d ov=%b, expected 3 0 0",
               n_pulse, exp_q.size(), l_out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_clear();
    logic [15:0] w;
    l_out_ready = 1'b1;
    l_in_valid = 1'b1;
    l_in_bit = 1'b1;
    for (int i = 0; i < 7; i++) step();
    n_cmp++;
    if (l_bit_idx !== 4'd7) begin
      n_fail++;
      $display("FAIL clear_pre_idx: idx=%0d expected 7", l_bit_idx);
    end
    l_clear = 1'b1;
    step();
    l_clear = 1'b0;
    n_cmp++;
    if (l_bit_idx !== 4'd0 || l_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_fill: idx=%0d ov=%b, expected 0 0", l_bit_idx, l_out_valid);
    end
    w = 16'h0F0F;
    for (int i = 0; i < 16; i++) begin
      l_in_bit = w[i];
      step();
    end
    l_in_valid = 1'b0;
    n_cmp++;
    if (l_out_valid !== 1'b1 || l_word_out !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL clear_next_word: ov=%b word=%h, expected 1 0f0f", l_out_valid, l_word_out);
    end
    step();
  endtask

  task automatic test_clear_hold();
    logic [15:0] w;
    w = 16'hBEEF;
    m_out_ready = 1'b0;
    m_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_in_bit = w[15 - i];
      step();
    end
    m_in_valid = 1'b0;
    m_clear = 1'b1;
    step();
    m_clear = 1'b0;
    n_cmp++;
    if (m_out_valid !== 1'b1 || m_word_out !== 16'hBEEF || m_bit_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_hold: ov=%b word=%h idx=%0d, expected 1 beef 0",
               m_out_valid, m_word_out, m_bit_idx);
    end
    step();
    step();
    n_cmp++;
    if (m_out_valid !== 1'b1 || m_word_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL clear_hold_retained: ov=%b word=%h, expected 1 beef", m_out_valid, m_word_out);
    end
    m_out_ready = 1'b1;
    step();
    m_out_ready = 1'b0;
    n_cmp++;
    if (m_out_valid !== 1'b0 || m_bit_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_hold_take: ov=%b idx=%0d, expected 0 0", m_out_valid, m_bit_idx);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_lsb_word();
    test_msb_backpressure();
    test_back_to_back();
    test_clear();
    test_clear_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Time limit so a broken run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bit_deserializer_16.md
# bit_deserializer_16

Sequential 1-to-16 bit distributor: accepts a serial bit stream under a valid/ready handshake and writes each accepted bit into the word position given by an internal 4-bit index, using a 1-to-16 write-enable decode. It is the receiving end of the 16:1 bit-select path in the ALU datapath. A 16-bit word serialized one bit per cycle by the select-mux side is reassembled here. The completed word is presented on a valid/ready output port.

## Interface
- MSB_FIRST, 0, bit order. 0: first accepted bit lands in word_out[0]. 1: first accepted bit lands in word_out[15].
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block can accept a bit this cycle.
- clear  input  1  synchronous abort of the partial word.
- word_out  output  16  assembled word, stable while out_valid=1.
- out_valid  output  1  word_out holds a complete word.
- out_ready  input  1  consumer takes word_out this cycle.
- bit_idx  output  4  number of bits accepted into the current partial word (0–15).

## Operation
- Bit accept: in_valid & in_ready.
- Word take: out_valid & out_ready.
- Write position:
  - MSB_FIRST=0: pos = bit_idx.
  - MSB_FIRST=1: pos = 15 - bit_idx.
  - The 4-bit position is decoded to a one-hot 16-bit write enable. Only word_out[pos] updates on an accept. All other bits hold.
- FSM, two states:
  - FILL (out_valid=0): in_ready=1. Each accept writes the bit and increments bit_idx (mod 16).
    - The accept at bit_idx=15 moves to HOLD, sets out_valid=1 and wraps bit_idx to 0.
  - HOLD (out_valid=1): word_out frozen. in_ready = out_ready.
    - Take without accept: go to FILL, out_valid=0.
    - Take with simultaneous accept: word_out is rebuilt for the next word. The new bit goes to pos for bit_idx=0, all other bits clear to 0. bit_idx=1, state FILL, out_valid=0.
    - No take: no accept possible, all state holds.
- Start of each new word (FILL with bit_idx=0, accept): bits other than pos clear to 0. A word never carries stale bits from the previous word.
- clear: bit_idx←0. Any partial word is discarded.
  - In FILL, clear has priority over a same-cycle accept; the bit is dropped.
  - In HOLD, clear does not drop the held word: out_valid and word_out are unaffected.
  - in_ready is unaffected by clear. Upstream must treat a bit offered with clear as lost.
- rst has priority over everything.

## Timing
- Reset values: word_out=16'h0000, out_valid=0, bit_idx=0, in_ready=1, state FILL.
- Latency: out_valid rises on the clock edge that accepts the 16th bit, visible the next cycle.
  - Minimum first word: 16 cycles from the first accept.
  - Sustained throughput: one bit/cycle, no bubbles between words, provided out_ready=1 while out_valid=1.
- in_ready is combinational from state and out_ready only. It never depends on in_valid.
- Reset mid-word or mid-HOLD: the partial or held word is lost. Outputs return to reset values on the next cycle.
- bit_idx wraps 15→0 only on the 16th accept; no other wrap.
- All outputs are registered except in_ready.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> word_out=0000, out_valid=0, bit_idx=0, in_ready=1. No bit is captured.
- LSB-first word: MSB_FIRST=0, out_ready=1, stream bits of 16'hA5C3 LSB first on 16 consecutive cycles.
  - out_valid=1 for exactly 1 cycle, word_out=A5C3.
  - bit_idx sequence is 0..15 then 0.
- MSB-first + backpressure: MSB_FIRST=1, send 16'h1234 MSB first with out_ready=0.
  - out_valid stays 1 and word_out=1234 stays frozen.
  - in_ready=0, and in_valid=1 for 5 cycles changes nothing.
  - Raise out_ready together with the first bit (1) of 16'h8001 -> out_valid=0, bit_idx=1.
  - The next word completes to 8001 with no stale bits.
- Back-to-back: out_ready=1, stream 48 bits (FFFF, 0000, 5555) -> three out_valid pulses exactly 16 cycles apart with the correct values.
- Clear: after 7 bits of 16'hFFFF, assert clear with in_valid=1 -> bit_idx=0 and that bit is dropped. The next 16 bits of 16'h0F0F yield word_out=0F0F.
- Clear in HOLD: with out_valid=1 holding BEEF, pulse clear -> word_out=BEEF and out_valid=1 are retained until the word is taken.
